// File: rtl/seg_scan6.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan6
// Purpose  : Six-digit common-anode seven-segment scanner with per-slot
//            blanking and frame-synchronous shadow latching of the digit bus.
//            Define SEG_SCAN_HELLO_FONT_EN to swap the hex font for the
//            "HELLO" message font.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan6 #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int SCAN_HZ   = 1000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] data_in,
   input  logic [5:0]  dp_in,
   output logic [5:0]  sel,
   output logic [7:0]  seg,
   output logic        frame_start
);

   localparam int c_dig_cyc = CLK_FREQ / SCAN_HZ;
   localparam int c_cnt_w   = (c_dig_cyc > 1) ? $clog2(c_dig_cyc) : 1;
   localparam bit c_has_blank = (BLANK_CYC > 0);
   localparam logic [c_cnt_w-1:0] c_dig_last   = c_cnt_w'(c_dig_cyc - 1);
   localparam logic [c_cnt_w-1:0] c_blank_last =
      c_has_blank ? c_cnt_w'(BLANK_CYC - 1) : {c_cnt_w{1'b0}};

   generate
      if (c_dig_cyc < BLANK_CYC + 2) begin : g_bad_params
         $error("seg_scan6: digit slot must be at least BLANK_CYC+2 cycles");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2:0]           r_idx;
   logic [23:0]          r_shadow_data;
   logic [5:0]           r_shadow_dp;

   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   w_cnt_nxt;
   logic [2:0]           w_idx_nxt;
   logic                 w_load;
   logic [5:0]           w_sel_nxt;
   logic [7:0]           w_seg_nxt;
   logic [3:0]           w_nibble;
   logic                 w_dp;
   logic [5:0]           w_sel_onehot;
   logic [7:0]           w_font;
   logic [7:0]           w_pattern;

   function automatic logic [7:0] font_lookup(input logic [3:0] code);
      logic [7:0] f;
`ifdef SEG_SCAN_HELLO_FONT_EN
      case (code)
         4'h0:    f = 8'h89;
         4'h1:    f = 8'h86;
         4'h2:    f = 8'hC7;
         4'h3:    f = 8'hC7;
         4'h4:    f = 8'hC0;
         default: f = 8'hFF;
      endcase
`else
      case (code)
         4'h0:    f = 8'hC0;
         4'h1:    f = 8'hF9;
         4'h2:    f = 8'hA4;
         4'h3:    f = 8'hB0;
         4'h4:    f = 8'h99;
         4'h5:    f = 8'h92;
         4'h6:    f = 8'h82;
         4'h7:    f = 8'hF8;
         4'h8:    f = 8'h80;
         4'h9:    f = 8'h90;
         4'hA:    f = 8'h88;
         4'hB:    f = 8'h83;
         4'hC:    f = 8'hC6;
         4'hD:    f = 8'hA1;
         4'hE:    f = 8'h86;
         default: f = 8'h8E;
      endcase
`endif
      return f;
   endfunction

   // Digit 0 is the MSB nibble of the bus but bit [5] of the dp vector.
   always_comb begin
      w_nibble     = 4'h0;
      w_dp         = 1'b0;
      w_sel_onehot = 6'h3F;
      case (r_idx)
         3'd0: begin w_nibble = r_shadow_data[23:20]; w_dp = r_shadow_dp[5]; w_sel_onehot = 6'b111110; end
         3'd1: begin w_nibble = r_shadow_data[19:16]; w_dp = r_shadow_dp[4]; w_sel_onehot = 6'b111101; end
         3'd2: begin w_nibble = r_shadow_data[15:12]; w_dp = r_shadow_dp[3]; w_sel_onehot = 6'b111011; end
         3'd3: begin w_nibble = r_shadow_data[11:8];  w_dp = r_shadow_dp[2]; w_sel_onehot = 6'b110111; end
         3'd4: begin w_nibble = r_shadow_data[7:4];   w_dp = r_shadow_dp[1]; w_sel_onehot = 6'b101111; end
         3'd5: begin w_nibble = r_shadow_data[3:0];   w_dp = r_shadow_dp[0]; w_sel_onehot = 6'b011111; end
         default: begin
            w_nibble     = 4'h0;
            w_dp         = 1'b0;
            w_sel_onehot = 6'h3F;
         end
      endcase
   end

   assign w_font    = font_lookup(w_nibble);
   assign w_pattern = {w_font[7] & ~w_dp, w_font[6:0]};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      w_sel_nxt   = 6'h3F;
      w_seg_nxt   = 8'hFF;
      case (r_state)
         ST_INIT: begin
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 3'd0;
            w_state_nxt = c_has_blank ? ST_BLANK : ST_SHOW;
         end
         ST_BLANK: begin
            // Segments lead the select so they are settled when it asserts.
            w_seg_nxt = w_pattern;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_blank_last) begin
               w_state_nxt = ST_SHOW;
            end
         end
         ST_SHOW: begin
            w_sel_nxt = w_sel_onehot;
            w_seg_nxt = w_pattern;
            if (r_cnt == c_dig_last) begin
               w_cnt_nxt   = '0;
               w_state_nxt = c_has_blank ? ST_BLANK : ST_SHOW;
               if (r_idx == 3'd5) begin
                  w_idx_nxt = 3'd0;
                  w_load    = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_INIT;
         r_cnt         <= '0;
         r_idx         <= 3'd0;
         r_shadow_data <= 24'h0;
         r_shadow_dp   <= 6'h0;
         sel           <= 6'h3F;
         seg           <= 8'hFF;
         frame_start   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         sel         <= w_sel_nxt;
         seg         <= w_seg_nxt;
         frame_start <= w_load;
         if (w_load) begin
            r_shadow_data <= data_in;
            r_shadow_dp   <= dp_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan6.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan6
// Purpose  : Directed self-checking bench for seg_scan6 (DIG_CYC=10, BLANK=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan6;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] data_in;
   logic [5:0]  dp_in;
   logic [5:0]  sel;
   logic [7:0]  seg;
   logic        frame_start;

   int n_vec = 0;
   int n_err = 0;

   logic        chg_pending = 1'b0;
   logic [23:0] chg_val     = 24'h0;

   logic [7:0] exp_012345 [6];
   logic [7:0] exp_all_f  [6];
   logic [7:0] exp_dp8    [6];
   logic [7:0] exp_501234 [6];

   seg_scan6 #(
      .CLK_FREQ  (1000),
      .SCAN_HZ   (100),
      .BLANK_CYC (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .sel         (sel),
      .seg         (seg),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One 10-cycle slot at the pins: 2 blank cycles, then 8 with digit d selected.
   task automatic check_slot(input int d, input logic [7:0] e);
      logic [5:0] es;
      for (int p = 0; p < 10; p++) begin
         @(negedge clk);
         es = (p < 2) ? 6'h3F : ~(6'd1 << d);
         chk("sel", {2'b00, sel}, {2'b00, es});
         chk("seg", seg, e);
         chk("frame_start", {7'd0, frame_start}, {7'd0, (d == 5 && p == 9)});
         if (chg_pending && d == 2 && p == 5) begin
            data_in     = chg_val;
            chg_pending = 1'b0;
         end
      end
   endtask

   task automatic check_post_reset();
      @(negedge clk);
      chk("init_fs",  {7'd0, frame_start}, 8'h01);
      chk("init_sel", {2'b00, sel}, 8'h3F);
      chk("init_seg", seg, 8'hFF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef SEG_SCAN_HELLO_FONT_EN
      exp_012345 = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF};
      exp_all_f  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_dp8    = '{8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
      exp_501234 = '{8'hFF, 8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0};
`else
      exp_012345 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
      exp_all_f  = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E};
      exp_dp8    = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
      exp_501234 = '{8'h92, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99};
`endif

      // Reset with arbitrary inputs.
      rst     = 1'b1;
      data_in = 24'($urandom);
      dp_in   = 6'($urandom);
      repeat (3) begin
         @(negedge clk);
         chk("rst_sel", {2'b00, sel}, 8'h3F);
         chk("rst_seg", seg, 8'hFF);
         chk("rst_fs",  {7'd0, frame_start}, 8'h00);
      end

      data_in = 24'h012345;
      dp_in   = 6'h00;
      rst     = 1'b0;
      check_post_reset();

      // Frame 0: plain scan.
      for (int d = 0; d < 6; d++) check_slot(d, exp_012345[d]);

      // Frame 1: bus changes during digit 2 SHOW; frame must not tear.
      chg_pending = 1'b1;
      chg_val     = 24'hFFFFFF;
      for (int d = 0; d < 6; d++) check_slot(d, exp_012345[d]);

      // Frame 2: new data visible; next inputs staged for frame 3.
      data_in = 24'h888888;
      dp_in   = 6'b100001;
      for (int d = 0; d < 6; d++) check_slot(d, exp_all_f[d]);

      // Frame 3: decimal points on digits 0 and 5.
      data_in = 24'h501234;
      dp_in   = 6'h00;
      for (int d = 0; d < 6; d++) check_slot(d, exp_dp8[d]);

      // Frame 4: rotated bus.
      for (int d = 0; d < 6; d++) check_slot(d, exp_501234[d]);

      // Frame 5: reset asserted mid-SHOW of digit 3.
      for (int d = 0; d < 3; d++) check_slot(d, exp_501234[d]);
      repeat (5) @(negedge clk);
      chk("pre_rst_sel", {2'b00, sel}, 8'h37);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_sel", {2'b00, sel}, 8'h3F);
      chk("async_rst_seg", seg, 8'hFF);
      chk("async_rst_fs",  {7'd0, frame_start}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      check_post_reset();
      check_slot(0, exp_501234[0]);
      check_slot(1, exp_501234[1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
